// File: rtl/mmu_result_drain_if.sv
// Result stream from the drain toward writeback/SRAM: ready/valid with
// a per-row tag and tile-boundary marker.
interface mmu_result_drain_if #(
    parameter int LANES = 4,
    parameter int OUT_W = 16,
    parameter int TAG_W = 5
);
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [TAG_W-1:0]         out_tag;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_tag,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mmu_result_drain.sv
// Result drain: requantizes an accumulator row (shift, round-half-up,
// saturate), tags it, marks tile boundaries and buffers it in a small
// first-word-fall-through FIFO. Rows arriving while the FIFO is full are
// dropped and counted.
module mmu_result_drain #(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       res_valid_i,
    input  logic [LANES*ACC_W-1:0]     acc_data_i,
    input  logic [2:0]                 op_code_i,
    input  logic [1:0]                 stage_i,
    input  logic [4:0]                 shift_i,
    input  logic [7:0]                 tile_len_i,
    input  logic                       clr_i,
    mmu_result_drain_if.master         out_if,
    output logic                       overflow_o,
    output logic [7:0]                 drop_cnt_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PW      = $clog2(DEPTH);
    localparam int LW      = PW + 1;
    localparam int DATA_W  = LANES * OUT_W;
    localparam int ENTRY_W = 1 + TAG_W + DATA_W;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [DATA_W-1:0]  req_row;

    // Per-lane requantization, one extra bit of headroom so rounding never wraps.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ACC_W-1:0]        acc_lane;
        logic signed [ACC_W:0]   acc_ext;
        logic signed [ACC_W:0]   shifted;
        logic signed [ACC_W:0]   rounded;
        logic                    rnd_bit;
        logic [OUT_W-1:0]        sat;

        assign acc_lane = acc_data_i[gi*ACC_W +: ACC_W];

        // Arithmetic shift, add the last bit shifted out, then clamp.
        always_comb begin
            acc_ext = $signed({acc_lane[ACC_W-1], acc_lane});
            shifted = acc_ext >>> shift_i;
            rnd_bit = (shift_i != 5'd0) ? acc_lane[shift_i - 5'd1] : 1'b0;
            rounded = shifted + $signed({{ACC_W{1'b0}}, rnd_bit});
            if (rounded > SAT_MAX) begin
                sat = SAT_MAX[OUT_W-1:0];
            end else if (rounded < SAT_MIN) begin
                sat = SAT_MIN[OUT_W-1:0];
            end else begin
                sat = rounded[OUT_W-1:0];
            end
        end

        assign req_row[gi*OUT_W +: OUT_W] = sat;
    end

    // Stage-1 register and control state
    logic                 s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]    s1_data_q,  s1_data_d;
    logic [TAG_W-1:0]     s1_tag_q,   s1_tag_d;
    logic                 s1_last_q,  s1_last_d;
    logic [7:0]           row_cnt_q,  row_cnt_d;
    logic [PW-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]        level_q,    level_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [ENTRY_W-1:0]   head;
    logic                 row_last;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // tile_len of 0 wraps to 255 here, giving 256-row tiles.
    assign row_last = (row_cnt_q == tile_len_i - 8'd1);
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = out_if.out_valid & out_if.out_ready & ~clr_i;
    assign push     = s1_valid_q & ~clr_i & (~full | pop);
    assign drop     = s1_valid_q & ~clr_i & full & ~pop;

    // Next-state for pipeline, pointers, occupancy and drop accounting.
    always_comb begin
        s1_valid_d = res_valid_i;
        s1_data_d  = res_valid_i ? req_row : s1_data_q;
        s1_tag_d   = res_valid_i ? {op_code_i, stage_i} : s1_tag_q;
        s1_last_d  = res_valid_i ? row_last : s1_last_q;
        row_cnt_d  = row_cnt_q;
        if (res_valid_i) begin
            row_cnt_d = row_last ? 8'd0 : row_cnt_q + 8'd1;
        end
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d    = level_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        if (clr_i) begin
            s1_valid_d = 1'b0;
            row_cnt_d  = 8'd0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_last_q  <= 1'b0;
            row_cnt_q  <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_last_q  <= s1_last_d;
            row_cnt_q  <= row_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because level gates the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s1_last_q, s1_tag_q, s1_data_q};
        end
    end

    // Fall-through head; outputs forced to zero whenever the FIFO is empty.
    always_comb begin
        head              = mem_q[rd_ptr_q];
        out_if.out_valid  = (level_q != '0);
        out_if.out_data   = out_if.out_valid ? head[DATA_W-1:0] : '0;
        out_if.out_tag    = out_if.out_valid ? head[DATA_W +: TAG_W] : '0;
        out_if.out_last   = out_if.out_valid ? head[ENTRY_W-1] : 1'b0;
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;
    assign level_o    = level_q;
endmodule

// File: tb/tb_mmu_result_drain.sv
// Directed bench for mmu_result_drain: requant math, latency, tiles,
// overflow, backpressure, soft clear and asynchronous reset.
module tb_mmu_result_drain;
    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid;
    logic [127:0]  acc;
    logic [2:0]    op_code;
    logic [1:0]    stage;
    logic [4:0]    shift;
    logic [7:0]    tile_len;
    logic          clr;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic [3:0]    level;

    int checks = 0;
    int errors = 0;

    mmu_result_drain_if #(.LANES(4), .OUT_W(16), .TAG_W(5)) out_if ();

    mmu_result_drain #(
        .LANES(4), .ACC_W(32), .OUT_W(16), .DEPTH(8), .TAG_W(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .res_valid_i (res_valid),
        .acc_data_i  (acc),
        .op_code_i   (op_code),
        .stage_i     (stage),
        .shift_i     (shift),
        .tile_len_i  (tile_len),
        .clr_i       (clr),
        .out_if      (out_if),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] acc4(input int a0, input int a1, input int a2, input int a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
    endfunction

    // Single row into an empty FIFO with out_ready=1: checks latency and data.
    task automatic one_row(input string name, input logic [127:0] a, input logic [4:0] sh,
                           input logic [63:0] exp);
        acc = a; shift = sh; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk({name, "_lat1"}, {63'd0, out_if.out_valid}, 64'd0);
        tick();
        chk({name, "_valid"}, {63'd0, out_if.out_valid}, 64'd1);
        chk({name, "_data"}, out_if.out_data, exp);
        tick();
    endtask

    task automatic soft_clear;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int next_exp;
        logic prev_stall;
        logic [63:0] prev_data;

        rst = 1'b1; res_valid = 1'b0; acc = '0; op_code = 3'd0; stage = 2'd0;
        shift = 5'd0; tile_len = 8'd0; clr = 1'b0; out_if.out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", {63'd0, out_if.out_valid}, 64'd0);
        chk("rst_data", out_if.out_data, 64'd0);
        chk("rst_tag", {59'd0, out_if.out_tag}, 64'd0);
        chk("rst_last", {63'd0, out_if.out_last}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
        chk("rst_level", {60'd0, level}, 64'd0);
        rst = 1'b0;
        tick();

        // Basic row: lane values and tag capture, 2-cycle latency.
        out_if.out_ready = 1'b1;
        op_code = 3'd5; stage = 2'd2;
        acc = acc4(100, -100, 7, 0); shift = 5'd2; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t1_lat1", {63'd0, out_if.out_valid}, 64'd0);
        tick();
        chk("t1_valid", {63'd0, out_if.out_valid}, 64'd1);
        chk("t1_data", out_if.out_data, pack4(25, -25, 2, 0));
        chk("t1_tag", {59'd0, out_if.out_tag}, 64'h16);
        chk("t1_last", {63'd0, out_if.out_last}, 64'd0);
        tick();
        chk("t1_popped", {63'd0, out_if.out_valid}, 64'd0);

        // Saturation at shift 0 and half-up rounding at shift 1.
        op_code = 3'd0; stage = 2'd0;
        one_row("t2_sat", acc4(70000, -70000, 32767, -32768), 5'd0,
                pack4(32767, -32768, 32767, -32768));
        one_row("t2_rnd", acc4(3, -3, 1, -1), 5'd1, pack4(2, -1, 1, 0));

        // Tile marking: tile_len=4, 9 back-to-back rows.
        soft_clear();
        tile_len = 8'd4; shift = 5'd0;
        for (int k = 0; k <= 10; k++) begin
            if (k >= 2) begin
                chk($sformatf("t3_valid%0d", k-2), {63'd0, out_if.out_valid}, 64'd1);
                chk($sformatf("t3_data%0d", k-2), out_if.out_data, pack4(k-2, 0, 0, 0));
                chk($sformatf("t3_last%0d", k-2), {63'd0, out_if.out_last},
                    ((k-2) == 3 || (k-2) == 7) ? 64'd1 : 64'd0);
            end
            res_valid = (k < 9);
            acc = acc4(k, 0, 0, 0);
            tick();
        end
        res_valid = 1'b0;
        chk("t3_level", {60'd0, level}, 64'd0);

        // Overflow: 10 rows into an 8-deep FIFO with no consumer.
        soft_clear();
        tile_len = 8'd0; out_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1; acc = acc4(i, 0, 0, 0);
            tick();
        end
        res_valid = 1'b0;
        tick(); tick();
        chk("t4_level", {60'd0, level}, 64'd8);
        chk("t4_ovf", {63'd0, overflow}, 64'd1);
        chk("t4_drop", {56'd0, drop_cnt}, 64'd2);
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_dvalid%0d", i), {63'd0, out_if.out_valid}, 64'd1);
            chk($sformatf("t4_drain%0d", i), out_if.out_data, pack4(i, 0, 0, 0));
            tick();
        end
        chk("t4_empty_level", {60'd0, level}, 64'd0);
        chk("t4_empty_valid", {63'd0, out_if.out_valid}, 64'd0);
        chk("t4_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Backpressure: out_ready toggles every cycle over 6 rows.
        soft_clear();
        next_exp = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 30; c++) begin
            out_if.out_ready = c[0];
            res_valid = (c < 6);
            acc = acc4(10 + c, 0, 0, 0);
            if (prev_stall)
                chk($sformatf("t5_hold%0d", c), out_if.out_data, prev_data);
            if (out_if.out_valid && out_if.out_ready) begin
                chk($sformatf("t5_order%0d", next_exp), out_if.out_data, pack4(10 + next_exp, 0, 0, 0));
                next_exp++;
            end
            prev_stall = out_if.out_valid && !out_if.out_ready;
            prev_data  = out_if.out_data;
            tick();
        end
        res_valid = 1'b0;
        chk("t5_count", 64'(next_exp), 64'd6);
        chk("t5_level", {60'd0, level}, 64'd0);

        // Soft clear with level=5, overflow set and a same-cycle res_valid.
        soft_clear();
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1; acc = acc4(i, 0, 0, 0);
            tick();
        end
        res_valid = 1'b0;
        tick(); tick();
        out_if.out_ready = 1'b1;
        tick(); tick(); tick();
        out_if.out_ready = 1'b0;
        chk("t6_level5", {60'd0, level}, 64'd5);
        chk("t6_ovf_pre", {63'd0, overflow}, 64'd1);
        clr = 1'b1; res_valid = 1'b1; out_if.out_ready = 1'b1;
        tick();
        clr = 1'b0; res_valid = 1'b0;
        chk("t6_level", {60'd0, level}, 64'd0);
        chk("t6_valid", {63'd0, out_if.out_valid}, 64'd0);
        chk("t6_ovf", {63'd0, overflow}, 64'd0);
        chk("t6_drop", {56'd0, drop_cnt}, 64'd0);
        tick(); tick();
        chk("t6_no_ghost", {63'd0, out_if.out_valid}, 64'd0);

        // Asynchronous reset mid-drain.
        out_if.out_ready = 1'b0; op_code = 3'd3; stage = 2'd1;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; acc = acc4(500 + i, 1, 1, 1);
            tick();
        end
        res_valid = 1'b0;
        tick(); tick();
        chk("t7_level3", {60'd0, level}, 64'd3);
        chk("t7_tag", {59'd0, out_if.out_tag}, 64'h0D);
        out_if.out_ready = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t7_valid", {63'd0, out_if.out_valid}, 64'd0);
        chk("t7_data", out_if.out_data, 64'd0);
        chk("t7_tagz", {59'd0, out_if.out_tag}, 64'd0);
        chk("t7_level", {60'd0, level}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t7_after", {63'd0, out_if.out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
